// File: rtl/countdown_timer.sv
// Loadable down-counter with run/hold/idle control, optional auto-reload,
// and a registered one-cycle done pulse on expiry or on a zero load.
module countdown_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;

    // State and output registers; clear discards any countdown in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: load beats stop, stop beats expiry.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            if (load_value == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = enable ? S_RUN : S_HOLD;
            end
        end else if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_HOLD: begin
                    if (enable) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!enable) begin
                        state_d = S_HOLD;
                    end else if (count_q == WIDTH'(1)) begin
                        done_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = S_IDLE;
                        end
                    end else if (count_q == '0) begin
                        // Unreachable guard: never wrap below zero.
                        state_d = S_IDLE;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
